tlc_timed_sequencer: RTL and testbench
======================================

Name: tlc_timed_sequencer

Overview:
Timed sequencer for the highway/farm-road intersection lights. It debounces the farm-road car sensor and enforces minimum highway green, maximum farm green, yellow and all-red clearance intervals with one shared cycle counter. It also accepts an emergency hold that keeps or returns right-of-way to the highway. It drives the same 2-bit hwy_TL/fwy_TL light buses as the existing intersection controller and replaces its untimed sequencing.

Parameters:
HWY_MIN_GREEN, 8, minimum cycles of highway green before a farm request is honoured (>=1)
FWY_MAX_GREEN, 6, maximum cycles of farm-road green (>=1)
YELLOW_TIME, 2, cycles of yellow on either road (>=1)
ALL_RED_TIME, 1, cycles of all-red clearance after each yellow (>=1)
DEBOUNCE, 2, consecutive high sensor samples required to register a car (>=1)
CNT_W, 4, timer/debounce counter width; must hold max(all of the above)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
farm_sensor_X  in  1  raw farm-road car sensor, already synchronous to clk
emergency_req  in  1  level; hold/return right-of-way to highway
hwy_TL  out  2  highway light: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED
fwy_TL  out  2  farm-road light, same encoding
fwy_grant  out  1  one-cycle pulse on the first cycle of farm green
state_o  out  3  current state encoding, for debug/verification

Behaviour:
- Reset (async assert, sync release by clk): state S_HG, timer 0, debounce count 0, car_present 0. Outputs: hwy_TL=GREEN, fwy_TL=RED, fwy_grant=0, state_o=0.
- Debounce: the count increments (saturating at DEBOUNCE) each cycle farm_sensor_X=1 and clears to 0 on any cycle it is 0. car_present is registered and equals (count==DEBOUNCE). It rises DEBOUNCE cycles after the first high sample and falls the cycle after the first low sample.
- Timer: cleared to 0 on every state change, otherwise +1 per cycle (saturating). "Timer expiry N" means timer==N-1, so the state lasts exactly N cycles.
- States: S_HG=0, S_HY=1, S_AR1=2, S_FG=3, S_FY=4, S_AR2=5.
  - S_HG: hwy GREEN, fwy RED. Goes to S_HY when timer>=HWY_MIN_GREEN-1 and car_present and !emergency_req; otherwise stays.
  - S_HY: hwy YELLOW, fwy RED. Goes to S_AR1 at YELLOW_TIME expiry.
  - S_AR1: both RED. Goes to S_FG at ALL_RED_TIME expiry.
  - S_FG: hwy RED, fwy GREEN. Goes to S_FY when !car_present, or emergency_req, or FWY_MAX_GREEN expiry.
  - S_FY: hwy RED, fwy YELLOW. Goes to S_AR2 at YELLOW_TIME expiry.
  - S_AR2: both RED. Goes to S_HG at ALL_RED_TIME expiry.
- Lights are Moore outputs decoded from the state register. Both roads are never non-RED simultaneously; this is a required invariant.
- Yellow and all-red intervals always run to completion; emergency_req and the sensor are ignored during them.
- Emergency asserted in S_HY or S_AR1 does not abort: S_FG is entered and left on the next cycle (one cycle of farm green).
- fwy_grant is registered: 1 exactly in the first cycle of S_FG.
- Reset mid-sequence (any state): next cycle after release shows hwy GREEN, fwy RED, and the full HWY_MIN_GREEN is re-timed.
- Sensor glitch shorter than DEBOUNCE cycles causes no state change.
- Undefined state encodings (6, 7) recover to S_AR2.

Decomposition:
- Package tlc_pkg: light encodings (GREEN/YELLOW/RED) and state encodings S_HG..S_AR2.
- One sub-module, tlc_sensor_debounce (params DEBOUNCE, CNT_W; ports clk, rst, farm_sensor_X, car_present).
- Timer and FSM live in the top module.

Test Plan:
(Defaults; cycle 0 = first clk edge after rst release.)
1. Idle: sensor 0, emergency 0 for 50 cycles -> hwy GREEN, fwy RED throughout; fwy_grant never pulses.
2. Car served to max: sensor 1 from cycle 0 -> car_present=1 at cycle 2. hwy YELLOW cycles 8-9, all-red 10, fwy GREEN 11-16 with fwy_grant=1 at 11, fwy YELLOW 17-18, all-red 19, hwy GREEN at 20.
3. Car leaves early: as scenario 2 but sensor drops at cycle 12 -> fwy YELLOW at 14, hwy GREEN at 17.
4. Glitch: sensor high for 1 cycle at cycle 20 -> car_present stays 0; no light change.
5. Emergency: sensor held high, emergency_req=1 at cycle 12 (in S_FG) -> fwy YELLOW at 13. Keeping emergency_req high holds S_HG indefinitely despite the sensor.
6. Reset mid-operation: assert rst asynchronously during S_FY -> outputs hwy GREEN / fwy RED immediately. After release with sensor high, hwy YELLOW first appears at cycle 8.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared encodings for the timed intersection sequencer: light codes and
// sequencer state codes (also exported on state_o for debug).
package tlc_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_AR1 = 3'd2,
        S_FG  = 3'd3,
        S_FY  = 3'd4,
        S_AR2 = 3'd5
    } state_t;

endpackage

// File: rtl/tlc_sensor_debounce.sv
// Farm-road sensor debouncer: car_present is raised only after DEBOUNCE
// consecutive high samples and dropped on the cycle after any low sample.
module tlc_sensor_debounce #(
    parameter int DEBOUNCE = 2,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic farm_sensor_X,
    output logic car_present
);
    import tlc_pkg::*;

    localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] db_cnt_r;
    logic [CNT_W-1:0] db_cnt_s;
    logic             car_present_r;

    // Next count: saturating run length of consecutive high samples
    always_comb begin
        db_cnt_s = db_cnt_r;
        if (!farm_sensor_X) begin
            db_cnt_s = CNT_ZERO;
        end else if (db_cnt_r != DB_MAX) begin
            db_cnt_s = db_cnt_r + CNT_ONE;
        end else begin
            db_cnt_s = db_cnt_r;
        end
    end

    // Count register and registered presence flag (flag tracks the new count)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_r      <= CNT_ZERO;
            car_present_r <= 1'b0;
        end else begin
            db_cnt_r      <= db_cnt_s;
            car_present_r <= (db_cnt_s == DB_MAX);
        end
    end

    assign car_present = car_present_r;

endmodule

// File: rtl/tlc_timed_sequencer.sv
// Timed highway/farm-road light sequencer. One shared timer measures every
// interval; it restarts at each state change so "expiry N" is timer == N-1.
module tlc_timed_sequencer #(
    parameter int HWY_MIN_GREEN = 8,
    parameter int FWY_MAX_GREEN = 6,
    parameter int YELLOW_TIME   = 2,
    parameter int ALL_RED_TIME  = 1,
    parameter int DEBOUNCE      = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       farm_sensor_X,
    input  logic       emergency_req,
    output logic [1:0] hwy_TL,
    output logic [1:0] fwy_TL,
    output logic       fwy_grant,
    output logic [2:0] state_o
);
    import tlc_pkg::*;

    localparam logic [CNT_W-1:0] HG_LAST  = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] FG_LAST  = CNT_W'(FWY_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] TMR_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TMR_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TMR_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] timer_r;
    logic             car_present_s;
    logic             fwy_grant_r;
    light_t           hwy_l_s;
    light_t           fwy_l_s;

    tlc_sensor_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) u_debounce (
        .clk           (clk),
        .rst           (rst),
        .farm_sensor_X (farm_sensor_X),
        .car_present   (car_present_s)
    );

    // Next-state decision; yellow and all-red always run to expiry
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_HG: begin
                if ((timer_r >= HG_LAST) && car_present_s && !emergency_req) begin
                    state_s = S_HY;
                end else begin
                    state_s = S_HG;
                end
            end
            S_HY: begin
                if (timer_r == Y_LAST) state_s = S_AR1;
                else                   state_s = S_HY;
            end
            S_AR1: begin
                if (timer_r == AR_LAST) state_s = S_FG;
                else                    state_s = S_AR1;
            end
            S_FG: begin
                if (!car_present_s || emergency_req || (timer_r == FG_LAST)) begin
                    state_s = S_FY;
                end else begin
                    state_s = S_FG;
                end
            end
            S_FY: begin
                if (timer_r == Y_LAST) state_s = S_AR2;
                else                   state_s = S_FY;
            end
            S_AR2: begin
                if (timer_r == AR_LAST) state_s = S_HG;
                else                    state_s = S_AR2;
            end
            // Corrupted encodings fall into a clearance interval before highway green
            default: state_s = S_AR2;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_HG;
        else     state_r <= state_s;
    end

    // Shared interval timer: restarts on every state change, saturates otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r <= TMR_ZERO;
        end else if (state_s != state_r) begin
            timer_r <= TMR_ZERO;
        end else if (timer_r != TMR_MAX) begin
            timer_r <= timer_r + TMR_ONE;
        end else begin
            timer_r <= timer_r;
        end
    end

    // Grant pulse lands in the first cycle of farm green
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fwy_grant_r <= 1'b0;
        else     fwy_grant_r <= (state_s == S_FG) && (state_r != S_FG);
    end

    // Moore light decode; anything unexpected shows all-red
    always_comb begin
        hwy_l_s = RED;
        fwy_l_s = RED;
        case (state_r)
            S_HG:    begin hwy_l_s = GREEN;  fwy_l_s = RED;    end
            S_HY:    begin hwy_l_s = YELLOW; fwy_l_s = RED;    end
            S_FG:    begin hwy_l_s = RED;    fwy_l_s = GREEN;  end
            S_FY:    begin hwy_l_s = RED;    fwy_l_s = YELLOW; end
            default: begin hwy_l_s = RED;    fwy_l_s = RED;    end
        endcase
    end

    assign hwy_TL    = hwy_l_s;
    assign fwy_TL    = fwy_l_s;
    assign fwy_grant = fwy_grant_r;
    assign state_o   = state_r;

endmodule

// File: tb/tb_tlc_timed_sequencer.sv
// Directed bench for tlc_timed_sequencer. Cycle k is the clock period that
// ends with the k-th rising edge after reset release; outputs are checked
// and inputs applied at the falling edge that opens each cycle.
module tb_tlc_timed_sequencer;

    logic       clk;
    logic       rst;
    logic       farm_sensor_X;
    logic       emergency_req;
    logic [1:0] hwy_TL;
    logic [1:0] fwy_TL;
    logic       fwy_grant;
    logic [2:0] state_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    tlc_timed_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .farm_sensor_X (farm_sensor_X),
        .emergency_req (emergency_req),
        .hwy_TL        (hwy_TL),
        .fwy_TL        (fwy_TL),
        .fwy_grant     (fwy_grant),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the vector and reports a miscompare
    task automatic check_vec(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected state from hand-computed phase boundaries (first cycle of each phase)
    function automatic int seg(int k, int hy, int ar1, int fg, int fy, int ar2, int hg);
        if (k < hy)  return 0;
        if (k < ar1) return 1;
        if (k < fg)  return 2;
        if (k < fy)  return 3;
        if (k < ar2) return 4;
        if (k < hg)  return 5;
        return 0;
    endfunction

    function automatic int exp_state(int scn, int k);
        case (scn)
            2:       return seg(k, 8, 10, 11, 17, 19, 20);
            3:       return seg(k, 8, 10, 11, 14, 16, 17);
            5:       return seg(k, 8, 10, 11, 13, 15, 16);
            7:       return seg(k, 8, 10, 11, 12, 14, 15);
            default: return 0;
        endcase
    endfunction

    function automatic logic exp_grant(int scn, int k);
        return (scn == 2 || scn == 3 || scn == 5 || scn == 7) && (k == 11);
    endfunction

    function automatic logic stim_sensor(int scn, int k);
        case (scn)
            1:       return 1'b0;
            4:       return (k == 20);
            3:       return (k < 12);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic stim_emerg(int scn, int k);
        case (scn)
            5:       return (k >= 12);
            7:       return (k >= 8);
            default: return 1'b0;
        endcase
    endfunction

    // Light codes for a state: GREEN 00, YELLOW 01, RED 10
    function automatic logic [1:0] hwy_of(int st);
        if (st == 0) return 2'b00;
        if (st == 1) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [1:0] fwy_of(int st);
        if (st == 3) return 2'b00;
        if (st == 4) return 2'b01;
        return 2'b10;
    endfunction

    task automatic do_reset();
        rst           = 1'b1;
        farm_sensor_X = 1'b0;
        emergency_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Run cycles 0..ncyc-1 of one scenario, checking every cycle
    task automatic run_scn(input int scn, input int ncyc);
        int st;
        for (int k = 0; k < ncyc; k++) begin
            st = exp_state(scn, k);
            check_vec($sformatf("s%0d_state", scn), k, {5'd0, state_o}, 8'(st));
            check_vec($sformatf("s%0d_hwy", scn),   k, {6'd0, hwy_TL},  {6'd0, hwy_of(st)});
            check_vec($sformatf("s%0d_fwy", scn),   k, {6'd0, fwy_TL},  {6'd0, fwy_of(st)});
            check_vec($sformatf("s%0d_grant", scn), k, {7'd0, fwy_grant}, {7'd0, exp_grant(scn, k)});
            farm_sensor_X = stim_sensor(scn, k);
            emergency_req = stim_emerg(scn, k);
            @(negedge clk);
        end
    endtask

    initial begin
        rst           = 1'b1;
        farm_sensor_X = 1'b0;
        emergency_req = 1'b0;

        // Idle highway
        do_reset();
        run_scn(1, 50);
        // Car served to maximum farm green
        do_reset();
        run_scn(2, 22);
        // Car leaves during farm green
        do_reset();
        run_scn(3, 20);
        // One-cycle sensor glitch
        do_reset();
        run_scn(4, 30);
        // Emergency during farm green, then held
        do_reset();
        run_scn(5, 40);
        // Emergency raised during highway yellow: one cycle of farm green
        do_reset();
        run_scn(7, 24);

        // Reset mid-sequence: cycle 18 is farm yellow
        do_reset();
        run_scn(2, 18);
        check_vec("pre_rst_state", 18, {5'd0, state_o}, 8'd4);
        #2 rst = 1'b1;
        #1;
        check_vec("async_rst_state", 18, {5'd0, state_o}, 8'd0);
        check_vec("async_rst_hwy",   18, {6'd0, hwy_TL},  8'h00);
        check_vec("async_rst_fwy",   18, {6'd0, fwy_TL},  8'h02);
        check_vec("async_rst_grant", 18, {7'd0, fwy_grant}, 8'h00);
        do_reset();
        run_scn(2, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
